rld: RTL and testbench



---
 rtl/rld.sv | 111 +++++++++++
 tb/tb_rld.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rld.sv
// Run-length decoder: expands each {cnt, dat} word into cnt+1 beats of dat (one beat in bypass).
// Latency 1 cycle from input acceptance to first beat; input stalls while a run is emitted or output is blocked.
module rld #(
    parameter int CW = 4,
    parameter int DW = 8,
    parameter int SW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctl_rst,
    input  logic              cfg_ena,
    input  logic [CW+DW-1:0]  sti_tdata,
    input  logic              sti_tlast,
    input  logic              sti_tvalid,
    output logic              sti_tready,
    output logic [DW-1:0]     sto_tdata,
    output logic              sto_tlast,
    output logic              sto_tvalid,
    input  logic              sto_tready,
    output logic [SW-1:0]     sts_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   dat;
    logic [CW-1:0]   rem;
    logic            lst;
    logic            mode;
    logic            live;
    logic            word_end;
    logic            in_xfer;
    logic            out_xfer;

    // A bypass word always ends on its first beat, whatever was left in rem.
    assign word_end = (rem == '0) || !mode;
    assign in_xfer  = sti_tvalid & sti_tready;
    assign out_xfer = sto_tvalid & sto_tready;
    assign sto_tdata = dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        sto_tvalid = 1'b0;
        sto_tlast  = 1'b0;
        sti_tready = 1'b0;
        case (state)
            IDLE: begin
                sti_tready = live & ~ctl_rst;
            end
            RUN: begin
                sto_tvalid = 1'b1;
                sto_tlast  = lst & word_end;
                sti_tready = live & ~ctl_rst & word_end & sto_tready;
            end
            default: begin
                sti_tready = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (ctl_rst) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_xfer) state_nxt = RUN;
                RUN:  if (out_xfer && word_end) state_nxt = in_xfer ? RUN : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // live holds off input acceptance for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live    <= 1'b0;
            dat     <= '0;
            rem     <= '0;
            lst     <= 1'b0;
            mode    <= 1'b0;
            sts_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (ctl_rst) begin
                rem     <= '0;
                sts_cnt <= '0;
            end else begin
                if (in_xfer) begin
                    dat  <= sti_tdata[DW-1:0];
                    rem  <= cfg_ena ? sti_tdata[CW+DW-1:DW] : '0;
                    lst  <= sti_tlast;
                    mode <= cfg_ena;
                end else if (out_xfer && !word_end) begin
                    rem <= rem - CW'(1);
                end
                if (out_xfer) begin
                    sts_cnt <= sts_cnt + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rld.sv
// Bench for rld: per-cycle beat-queue model plus directed tests with literal expectations.
module tb_rld;
    localparam int CW = 4;
    localparam int DW = 8;
    localparam int SW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ctl_rst = 1'b0;
    logic             cfg_ena = 1'b1;
    logic [CW+DW-1:0] sti_tdata = '0;
    logic             sti_tlast = 1'b0;
    logic             sti_tvalid = 1'b0;
    logic             sti_tready;
    logic [DW-1:0]    sto_tdata;
    logic             sto_tlast;
    logic             sto_tvalid;
    logic             sto_tready = 1'b0;
    logic [SW-1:0]    sts_cnt;

    int checks = 0;
    int failures = 0;
    logic rdy_val = 1'b0;
    logic rand_mode = 1'b0;

    // Expected beats of the word in flight: {last, dat}.
    logic [DW:0]   q[$];
    logic [SW-1:0] msts = '0;
    logic          warm = 1'b0;
    int            cyc = 0;
    int            got_dat[$];
    int            got_lst[$];
    int            got_cyc[$];

    rld #(.CW(CW), .DW(DW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .ctl_rst(ctl_rst), .cfg_ena(cfg_ena),
        .sti_tdata(sti_tdata), .sti_tlast(sti_tlast), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
        .sto_tdata(sto_tdata), .sto_tlast(sto_tlast), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
        .sts_cnt(sts_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        sto_tready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            msts = '0;
            warm = 1'b0;
        end else begin
            chk("sts_cnt", 64'(sts_cnt), 64'(msts));
            chk("sto_tvalid", 64'(sto_tvalid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("sto_tdata", 64'(sto_tdata), 64'(q[0][DW-1:0]));
                chk("sto_tlast", 64'(sto_tlast), 64'(q[0][DW]));
            end
            chk("sti_tready", 64'(sti_tready),
                64'(warm && !ctl_rst && (q.size() == 0 || (q.size() == 1 && sto_tready))));
            if (ctl_rst) begin
                q.delete();
                msts = '0;
            end else begin
                if (sto_tvalid && sto_tready && q.size() != 0) begin
                    got_dat.push_back(int'(sto_tdata));
                    got_lst.push_back(int'(sto_tlast));
                    got_cyc.push_back(cyc);
                    void'(q.pop_front());
                    msts = msts + 1;
                end
                if (sti_tvalid && sti_tready) begin
                    int n;
                    n = cfg_ena ? int'(sti_tdata[CW+DW-1:DW]) + 1 : 1;
                    for (int k = 0; k < n; k++)
                        q.push_back({(k == n - 1) & sti_tlast, sti_tdata[DW-1:0]});
                end
            end
            warm = 1'b1;
        end
    end

    task automatic send(input int c, input int d, input logic l);
        int  n;
        logic acc;
        n = 0;
        sti_tdata  = {CW'(c), DW'(d)};
        sti_tlast  = l;
        sti_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            acc = sti_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) begin
                chk("send_timeout", 64'(n), 64'(0));
                break;
            end
        end
        sti_tvalid = 1'b0;
        sti_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || sto_tvalid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 400), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_dat.delete();
        got_lst.delete();
        got_cyc.delete();
    endtask

    task automatic chk_beats(input string nm, input int exp[$]);
        chk({nm, "_count"}, 64'(got_dat.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_dat.size(); i++) begin
            chk({nm, "_dat"}, 64'(got_dat[i]), 64'(exp[i]));
            chk({nm, "_last"}, 64'(got_lst[i]), 64'(i == exp.size() - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int exp[$];
        int raw[$];
        int wc[$];
        int wd[$];
        int tcount;

        rdy_val = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sti_tready", 64'(sti_tready), 64'(0));
        chk("rst_sto_tvalid", 64'(sto_tvalid), 64'(0));
        chk("rst_sto_tdata", 64'(sto_tdata), 64'(0));
        chk("rst_sto_tlast", 64'(sto_tlast), 64'(0));
        chk("rst_sts_cnt", 64'(sts_cnt), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic decode
        clear_log();
        send(0, 4, 0); send(1, 5, 0); send(2, 6, 0); send(3, 7, 1);
        wait_done();
        exp = '{4, 5, 5, 6, 6, 6, 7, 7, 7, 7};
        chk_beats("decode", exp);
        chk("decode_sts", 64'(sts_cnt), 64'(10));

        // Round trip through a bench-side compressor, random output backpressure
        raw = '{0, 0, 1, 2, 2, 3, 3, 3};
        for (int i = 0; i < 20; i++) raw.push_back(4);
        raw.push_back(2); raw.push_back(3); raw.push_back(3); raw.push_back(3);
        for (int i = 0; i < raw.size();) begin
            int r;
            r = 1;
            while (i + r < raw.size() && raw[i + r] == raw[i] && r < 16) r++;
            wc.push_back(r - 1);
            wd.push_back(raw[i]);
            i += r;
        end
        chk("rt_words", 64'(wc.size()), 64'(8));
        chk("rt_w4_cnt", 64'(wc[4]), 64'(15));
        chk("rt_w5_cnt", 64'(wc[5]), 64'(3));
        ctl_rst = 1'b1;
        @(posedge clk);
        #1;
        ctl_rst = 1'b0;
        clear_log();
        rand_mode = 1'b1;
        for (int i = 0; i < wc.size(); i++) send(wc[i], wd[i], i == wc.size() - 1);
        wait_done();
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        chk_beats("roundtrip", raw);
        chk("roundtrip_sts", 64'(sts_cnt), 64'(32));

        // Max run: input held off for the first 15 beats
        clear_log();
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back(8'hA5);
        send(15, 8'hA5, 1);
        tcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sto_tvalid && sti_tready) tcount++;
        end
        wait_done();
        chk("maxrun_ready_beats", 64'(tcount), 64'(1));
        chk_beats("maxrun", exp);

        // Bypass, then a mode change while a bypass word is being emitted
        clear_log();
        cfg_ena = 1'b0;
        send(3, 1, 0); send(7, 2, 0); send(0, 3, 1);
        wait_done();
        exp = '{1, 2, 3};
        chk_beats("bypass", exp);
        clear_log();
        send(5, 9, 1);
        cfg_ena = 1'b1;
        wait_done();
        exp = '{9};
        chk_beats("bypass_toggle", exp);

        // Output stall mid-run
        clear_log();
        send(6, 8'h33, 1);
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_vld", 64'(sto_tvalid), 64'(1));
            chk("stall_dat", 64'(sto_tdata), 64'(8'h33));
            chk("stall_last", 64'(sto_tlast), 64'(0));
            chk("stall_rdy", 64'(sti_tready), 64'(0));
        end
        rdy_val = 1'b1;
        wait_done();
        exp = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        chk_beats("stall", exp);

        // Back-to-back single-beat words: one beat per cycle
        clear_log();
        for (int i = 0; i < 6; i++) send(0, 10 + i, i == 5);
        wait_done();
        exp = '{10, 11, 12, 13, 14, 15};
        chk_beats("b2b", exp);
        for (int i = 1; i < got_cyc.size(); i++)
            chk("b2b_gap", 64'(got_cyc[i] - got_cyc[i - 1]), 64'(1));

        // Soft clear on the third beat of a run
        clear_log();
        send(7, 8, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        ctl_rst = 1'b1;
        @(posedge clk);
        #1;
        ctl_rst = 1'b0;
        chk("ctl_vld", 64'(sto_tvalid), 64'(0));
        chk("ctl_sts", 64'(sts_cnt), 64'(0));
        chk("ctl_beats", 64'(got_dat.size()), 64'(2));
        clear_log();
        send(0, 1, 1);
        wait_done();
        exp = '{1};
        chk_beats("ctl_after", exp);

        // Asynchronous reset mid-run
        send(9, 8'h77, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_vld", 64'(sto_tvalid), 64'(0));
        chk("arst_dat", 64'(sto_tdata), 64'(0));
        chk("arst_last", 64'(sto_tlast), 64'(0));
        chk("arst_sts", 64'(sts_cnt), 64'(0));
        chk("arst_rdy", 64'(sti_tready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        send(1, 8'h42, 1);
        wait_done();
        exp = '{8'h42, 8'h42};
        chk_beats("arst_after", exp);
        chk("arst_after_sts", 64'(sts_cnt), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
